// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory store buffer.
// Entry layout is sized for a 32-bit byte address and a 32-bit data word.
package dm_pkg;

   localparam int BE_W   = 4;
   localparam int LANE_W = 8;
   localparam int SB_AW  = 32;
   localparam int SB_DW  = 32;

   typedef struct packed {
      logic              valid;
      logic [SB_AW-3:0]  addr;
      logic [SB_DW-1:0]  data;
      logic [BE_W-1:0]   be;
      logic [31:0]       pc;
   } sb_entry_t;

   // Distance of a slot from the head; a larger value means a younger entry.
   function automatic int unsigned age(input int unsigned idx, input int unsigned head,
                                       input int unsigned depth);
      return (idx + depth - head) % depth;
   endfunction

endpackage

// File: rtl/sb_fwd_lane.sv
// Per-byte-lane forwarding select: picks the youngest valid, address-matching
// entry whose byte enable covers this lane.
module sb_fwd_lane
   import dm_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int IW   = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]        valid_i,
   input  logic [DEPTH-1:0]        match_i,
   input  logic [DEPTH-1:0]        be_i,
   input  logic [DEPTH*LANE_W-1:0] bytes_i,
   input  logic [IW-1:0]           head_i,
   output logic [LANE_W-1:0]       byte_o,
   output logic                    hit_o
);

   int unsigned best_age;

   always_comb begin
      byte_o   = '0;
      hit_o    = 1'b0;
      best_age = 0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_i[i] && match_i[i] && be_i[i]) begin
            if (!hit_o || age(int'(i), int'(head_i), DEPTH) > best_age) begin
               best_age = age(int'(i), int'(head_i), DEPTH);
               byte_o   = bytes_i[i*LANE_W +: LANE_W];
               hit_o    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dm_store_buffer.sv
// In-order store buffer between the MEM-stage store path and the data memory
// write port, with byte-granular forwarding to same-word loads.
module dm_store_buffer
   import dm_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32,
   localparam int IW   = $clog2(DEPTH),
   localparam int CW   = IW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          st_valid,
   output logic          st_ready,
   input  logic [AW-1:0] st_addr,
   input  logic [DW-1:0] st_data,
   input  logic [3:0]    st_be,
   input  logic [31:0]   st_pc,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] dm_rdata,
   output logic [DW-1:0] ld_data,
   output logic          ld_hit,
   input  logic          dm_ready,
   output logic          dm_we,
   output logic [AW-1:0] dm_addr,
   output logic [DW-1:0] dm_wdata,
   output logic [3:0]    dm_be,
   output logic [31:0]   dm_pc,
   output logic [CW-1:0] count,
   output logic          empty
);

   sb_entry_t     mem_q [DEPTH];
   logic [IW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;

   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign st_ready = (count_q != CW'(DEPTH));
   assign dm_we    = !empty && dm_ready;
   // Zero-enable stores complete the handshake but never occupy a slot.
   assign push     = st_valid && st_ready && (st_be != 4'b0000);
   assign pop      = dm_we;

   always_comb begin
      head_d  = pop  ? head_q + 1'b1 : head_q;
      tail_d  = push ? tail_q + 1'b1 : tail_q;
      count_d = count_q;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (pop) mem_q[head_q].valid <= 1'b0;
         if (push) mem_q[tail_q] <= '{valid: 1'b1, addr: st_addr[AW-1:2], data: st_data,
                                      be: st_be, pc: st_pc};
      end
   end

   always_comb begin
      dm_addr  = '0;
      dm_wdata = '0;
      dm_be    = '0;
      dm_pc    = '0;
      if (!empty) begin
         dm_addr  = {mem_q[head_q].addr, 2'b00};
         dm_wdata = mem_q[head_q].data;
         dm_be    = mem_q[head_q].be;
         dm_pc    = mem_q[head_q].pc;
      end
   end

   logic [DEPTH-1:0]        ent_valid, ent_match;
   logic [DEPTH-1:0]        ent_be   [BE_W];
   logic [DEPTH*LANE_W-1:0] ent_byte [BE_W];
   logic [LANE_W-1:0]       lane_byte [BE_W];
   logic [BE_W-1:0]         lane_hit;

   always_comb begin
      ent_valid = '0;
      ent_match = '0;
      for (int b = 0; b < BE_W; b++) begin
         ent_be[b]   = '0;
         ent_byte[b] = '0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         ent_valid[i] = mem_q[i].valid;
         ent_match[i] = (mem_q[i].addr == ld_addr[AW-1:2]);
         for (int b = 0; b < BE_W; b++) begin
            ent_be[b][i]                   = mem_q[i].be[b];
            ent_byte[b][i*LANE_W +: LANE_W] = mem_q[i].data[b*LANE_W +: LANE_W];
         end
      end
   end

   for (genvar b = 0; b < BE_W; b++) begin : g_lane
      sb_fwd_lane #(.DEPTH(DEPTH)) u_lane (
         .valid_i (ent_valid),
         .match_i (ent_match),
         .be_i    (ent_be[b]),
         .bytes_i (ent_byte[b]),
         .head_i  (head_q),
         .byte_o  (lane_byte[b]),
         .hit_o   (lane_hit[b])
      );
      assign ld_data[b*LANE_W +: LANE_W] = lane_hit[b] ? lane_byte[b]
                                                       : dm_rdata[b*LANE_W +: LANE_W];
   end

   assign ld_hit = |lane_hit;

endmodule

// File: tb/tb_dm_store_buffer.sv
// Bench for dm_store_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dm_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid, st_ready;
   logic [31:0] st_addr, st_data, st_pc, ld_addr, dm_rdata, ld_data;
   logic [3:0]  st_be, dm_be;
   logic        ld_hit, dm_ready, dm_we, empty;
   logic [31:0] dm_addr, dm_wdata, dm_pc;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;

   dm_store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
      .st_be(st_be), .st_pc(st_pc),
      .ld_addr(ld_addr), .dm_rdata(dm_rdata), .ld_data(ld_data), .ld_hit(ld_hit),
      .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_be(dm_be), .dm_pc(dm_pc), .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: program-order queue of pending stores, oldest at index 0.
   typedef struct {
      logic [29:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] pc;
   } ent_t;

   ent_t mq[$];
   bit   model_on = 0;

   always @(posedge clk) begin
      if (!reset) begin
         mq.delete();
         model_on = 1;
      end else if (model_on) begin
         bit do_pop, do_push;
         do_pop  = (mq.size() > 0) && dm_ready;
         do_push = (mq.size() < DEPTH) && st_valid && (st_be != 0);
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back('{a: st_addr[31:2], d: st_data, be: st_be, pc: st_pc});
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         logic [31:0] exp_ld;
         logic        exp_hit;
         exp_ld  = dm_rdata;
         exp_hit = 0;
         for (int i = 0; i < mq.size(); i++)
            if (mq[i].a == ld_addr[31:2])
               for (int b = 0; b < 4; b++)
                  if (mq[i].be[b]) begin
                     exp_ld[b*8 +: 8] = mq[i].d[b*8 +: 8];
                     exp_hit = 1;
                  end
         chk("count",    32'(count),    32'(mq.size()));
         chk("empty",    32'(empty),    32'(mq.size() == 0));
         chk("st_ready", 32'(st_ready), 32'(mq.size() != DEPTH));
         chk("dm_we",    32'(dm_we),    32'(mq.size() != 0 && dm_ready));
         chk("dm_addr",  dm_addr,  mq.size() ? {mq[0].a, 2'b00} : 32'h0);
         chk("dm_wdata", dm_wdata, mq.size() ? mq[0].d : 32'h0);
         chk("dm_be",    32'(dm_be), mq.size() ? 32'(mq[0].be) : 32'h0);
         chk("dm_pc",    dm_pc,    mq.size() ? mq[0].pc : 32'h0);
         chk("ld_data",  ld_data,  exp_ld);
         chk("ld_hit",   32'(ld_hit), 32'(exp_hit));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      st_valid = 1; st_addr = a; st_data = d; st_be = be; st_pc = 32'h1000 + a;
      tick();
      st_valid = 0;
   endtask

   initial begin
      reset = 0; st_valid = 0; st_addr = 0; st_data = 0; st_be = 0; st_pc = 0;
      ld_addr = 0; dm_rdata = 0; dm_ready = 0;
      tick(); tick();
      reset = 1;
      mid();
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_ready", 32'(st_ready), 32'd1);
      chk("rst_we",    32'(dm_we), 32'd0);
      chk("rst_hit",   32'(ld_hit), 32'd0);
      tick();

      // Fill to capacity, refuse a fifth store, then drain in order.
      dm_ready = 0;
      for (int i = 0; i < 4; i++) store(32'h10 + 4*i, 32'h11111111 * (i + 1), 4'hF);
      st_valid = 1; st_addr = 32'h20; st_data = 32'h55555555; st_be = 4'hF;
      mid();
      chk("fill_count", 32'(count), 32'd4);
      chk("fill_ready", 32'(st_ready), 32'd0);
      tick();
      st_valid = 0;
      mid();
      chk("fill_count5", 32'(count), 32'd4);
      tick();
      dm_ready = 1;
      for (int i = 0; i < 4; i++) begin
         mid();
         chk("drain_we",   32'(dm_we), 32'd1);
         chk("drain_addr", dm_addr, 32'h10 + 4*i);
         chk("drain_data", dm_wdata, 32'h11111111 * (i + 1));
         tick();
      end
      mid();
      chk("drain_empty", 32'(empty), 32'd1);
      tick();

      // Partial byte forward.
      dm_ready = 0;
      store(32'h21, 32'h0000AB00, 4'b0010);
      ld_addr = 32'h20; dm_rdata = 32'h44332211;
      mid();
      chk("pfwd_data", ld_data, 32'h4433AB11);
      chk("pfwd_hit",  32'(ld_hit), 32'd1);
      tick();
      dm_ready = 1; tick(); dm_ready = 0;

      // Youngest writer wins per lane.
      store(32'h40, 32'hAAAAAAAA, 4'hF);
      store(32'h40, 32'h0000BBBB, 4'b0011);
      store(32'h40, 32'hCCCCCCCC, 4'b1100);
      ld_addr = 32'h40; dm_rdata = 32'h12345678;
      mid();
      chk("young_data", ld_data, 32'hCCCCBBBB);
      chk("young_hit",  32'(ld_hit), 32'd1);
      tick();
      dm_ready = 1; tick(); tick(); tick(); dm_ready = 0;

      // Steady push+pop at count 2 across pointer wrap.
      store(32'h100, 32'hA0000000, 4'hF);
      store(32'h104, 32'hA0000001, 4'hF);
      dm_ready = 1;
      for (int i = 0; i < 2*DEPTH; i++) begin
         st_valid = 1; st_addr = 32'h108 + 4*i; st_data = 32'hA0000002 + i; st_be = 4'hF;
         st_pc = 32'h2000 + i;
         mid();
         chk("pp_count", 32'(count), 32'd2);
         tick();
      end
      st_valid = 0;
      tick(); tick();
      mid();
      chk("pp_empty", 32'(empty), 32'd1);
      tick();

      // Reset while draining discards everything.
      dm_ready = 0;
      store(32'h300, 32'h1, 4'hF);
      store(32'h304, 32'h2, 4'hF);
      store(32'h308, 32'h3, 4'hF);
      ld_addr = 32'h304;
      dm_ready = 1; reset = 0;
      tick();
      reset = 1;
      mid();
      chk("rmid_count", 32'(count), 32'd0);
      chk("rmid_we",    32'(dm_we), 32'd0);
      chk("rmid_hit",   32'(ld_hit), 32'd0);
      chk("rmid_ready", 32'(st_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         mid();
         chk("rmid_nowe", 32'(dm_we), 32'd0);
      end
      tick();

      // Zero-enable store is accepted but enqueues nothing.
      dm_ready = 1;
      st_valid = 1; st_addr = 32'h50; st_data = 32'hDEADBEEF; st_be = 4'b0000;
      mid();
      chk("zbe_ready", 32'(st_ready), 32'd1);
      tick();
      st_valid = 0;
      mid();
      chk("zbe_count", 32'(count), 32'd0);
      chk("zbe_we",    32'(dm_we), 32'd0);
      tick();

      // Randomized traffic over a small set of colliding words.
      for (int n = 0; n < 800; n++) begin
         st_valid = ($urandom_range(0, 9) < 6);
         st_addr  = 32'h200 + 4*$urandom_range(0, 3) + $urandom_range(0, 3);
         st_data  = $urandom;
         st_be    = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
         st_pc    = $urandom;
         ld_addr  = 32'h200 + 4*$urandom_range(0, 4) + $urandom_range(0, 3);
         dm_rdata = $urandom;
         dm_ready = ($urandom_range(0, 9) < 4);
         reset    = ($urandom_range(0, 99) != 0);
         tick();
      end
      reset = 1; st_valid = 0; dm_ready = 1;
      tick(); tick(); tick(); tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
